// File: rtl/ram_ctrl.sv
// ram_ctrl: request-side controller for a single-port tri-state-bus RAM.
// Turns a valid/ready request stream into two-cycle write and read strobe
// sequences, inserts a bus turnaround cycle after every write, and returns
// read data on a valid/ready response channel. The data bus is kept split
// (mem_wdata / mem_oe / mem_rdata); the enclosing top level builds the
// tri-state pad from these.
module ram_ctrl #(
  parameter int DATA_WIDE = 32,
  parameter int DEEP      = 512,
  parameter int ADDR_WIDE = $clog2(DEEP)
) (
  input  logic                 clk,
  input  logic                 rst,
  // request channel
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_WIDE-1:0] req_addr,
  input  logic [DATA_WIDE-1:0] req_wdata,
  // response channel
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_WIDE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 wr_done,
  // RAM side
  output logic                 mem_wr_en,
  output logic                 mem_re_en,
  output logic [ADDR_WIDE-1:0] mem_addr,
  output logic [DATA_WIDE-1:0] mem_wdata,
  output logic                 mem_oe,
  input  logic [DATA_WIDE-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR1  = 3'd1,
    S_WR2  = 3'd2,
    S_TURN = 3'd3,
    S_RD1  = 3'd4,
    S_RD2  = 3'd5,
    S_RESP = 3'd6
  } state_t;

  // One extra bit so DEEP itself is representable when DEEP is a power of 2.
  localparam logic [ADDR_WIDE:0] DEEP_LIM = (ADDR_WIDE + 1)'(DEEP);

  state_t               state_reg;
  state_t               state_next;
  logic [ADDR_WIDE-1:0] addr_reg;
  logic [DATA_WIDE-1:0] wdata_reg;
  logic [DATA_WIDE-1:0] rdata_reg;
  logic                 err_reg;
  logic                 accept;
  logic                 in_range;

  // Addresses are used verbatim; anything at or beyond DEEP is rejected.
  assign in_range = ({1'b0, req_addr} < DEEP_LIM);
  assign accept   = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode: fixed two-cycle strobes, turnaround after writes,
  // response held until the consumer takes it.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (req_we) begin
            state_next = in_range ? S_WR1 : S_TURN;
          end else begin
            state_next = in_range ? S_RD1 : S_RESP;
          end
        end
      end
      S_WR1:  state_next = S_WR2;
      S_WR2:  state_next = S_TURN;
      S_TURN: state_next = S_IDLE;
      S_RD1:  state_next = S_RD2;
      S_RD2:  state_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode: strobes come straight from the state so the bus driver
  // (mem_oe) can only ever be on in WR1/WR2, never alongside a read enable.
  always_comb begin
    mem_wr_en = 1'b0;
    mem_re_en = 1'b0;
    mem_oe    = 1'b0;
    wr_done   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_reg)
      S_WR1, S_WR2: begin
        mem_wr_en = 1'b1;
        mem_oe    = 1'b1;
      end
      S_RD1, S_RD2: mem_re_en = 1'b1;
      S_TURN:       wr_done   = 1'b1;
      S_RESP:       rsp_valid = 1'b1;
      default: ;
    endcase
    // Held low while reset is asserted so nothing is accepted mid-reset.
    req_ready = (state_reg == S_IDLE) && !rsp_valid && !rst;
  end

  // Request latch and read-data capture; everything here is held stable
  // across the strobe and response cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg <= req_addr;
        if (req_we) begin
          wdata_reg <= req_wdata;
        end else if (!in_range) begin
          rdata_reg <= '0;
          err_reg   <= 1'b1;
        end
      end
      if (state_reg == S_RD2) begin
        rdata_reg <= mem_rdata;
        err_reg   <= 1'b0;
      end
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule
